// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, bus condition levels, default address.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_PTR,
    ST_ACK_PTR,
    ST_WDATA,
    ST_ACK_WDATA,
    ST_RDATA,
    ST_RACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

  // SDA level on the acknowledge bit.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // SDA level reached by the edge that forms a START (falls) or STOP (rises)
  // while SCL is high.
  localparam logic I2C_START_SDA = 1'b0;
  localparam logic I2C_STOP_SDA  = 1'b1;

  // R/W bit value requesting a read.
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises the SCL/SDA pins into clk and flags SCL edges plus START/STOP.
// Events are single-cycle pulses, SYNC_STAGES+1 clk after the pin changes.
module i2c_bus_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchroniser chains plus one history stage; reset to the idle-high bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  // Edge and bus-condition decode; START/STOP need SCL high on both samples.
  always_comb begin
    sda_o      = sda_s;
    scl_rise_o = scl_s & ~scl_prev_q;
    scl_fall_o = ~scl_s & scl_prev_q;
    start_o    = scl_s & scl_prev_q & (sda_s != sda_prev_q) & (sda_s == I2C_START_SDA);
    stop_o     = scl_s & scl_prev_q & (sda_s != sda_prev_q) & (sda_s == I2C_STOP_SDA);
  end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file: pointer write, auto-increment
// multi-byte writes and reads, repeated START, host-side register port.
// The ACK-state phase is tracked by sda_oe_q itself: the first SCL fall in an
// ACK state pulls SDA low, the second releases it and moves on.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
  parameter int         NUM_REGS    = 16,
  parameter int         PTR_W       = $clog2(NUM_REGS),
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] host_addr,
  input  logic             host_we,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy,
  output i2c_state_e       dbg_state_o
);

  logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (bus_start),
    .stop_o     (bus_stop)
  );

  i2c_state_e       state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d;
  logic             rw_q, rw_d;
  logic             busy_q, busy_d;
  logic             commit_d;
  logic             wr_strobe_q;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       rx_byte;
  logic [7:0]       rd_byte;

  assign rx_byte = {shift_q[6:0], sda_s};
  assign rd_byte = regs_q[ptr_q];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath next values; STOP and START override every state.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    commit_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (bus_stop) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (bus_start) begin
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ST_ADDR) begin
                rw_d = rx_byte[0];
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = ST_ACK_ADDR;
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_WAIT_STOP;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_PTR) begin
                if (int'(rx_byte) < NUM_REGS) begin
                  ptr_d   = rx_byte[PTR_W-1:0];
                  state_d = ST_ACK_PTR;
                end else begin
                  state_d = ST_WAIT_STOP;
                end
              end else begin
                commit_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_byte;
                ptr_d     = ptr_q + PTR_W'(1);
                state_d   = ST_ACK_WDATA;
              end
            end
          end
        end
        ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_WDATA: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = ~I2C_ACK;
            end else if (state_q == ST_ACK_ADDR && rw_q == I2C_RW_READ) begin
              // Fall ending the ACK also presents read bit 7.
              sda_oe_d  = ~rd_byte[7];
              shift_d   = {rd_byte[6:0], 1'b0};
              bit_cnt_d = 4'd1;
              ptr_d     = ptr_q + PTR_W'(1);
              state_d   = ST_RDATA;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = (state_q == ST_ACK_ADDR) ? ST_PTR : ST_WDATA;
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RACK;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_RACK: begin
          // bit_cnt_q marks that the master's ACK has been sampled.
          if (scl_rise) begin
            if (sda_s == I2C_NACK) state_d = ST_WAIT_STOP;
            else                   bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            sda_oe_d  = ~rd_byte[7];
            shift_d   = {rd_byte[6:0], 1'b0};
            bit_cnt_d = 4'd1;
            ptr_d     = ptr_q + PTR_W'(1);
            state_d   = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      wr_strobe_q <= commit_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Register file; an I2C commit beats a host write to the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_d && wr_addr_d == PTR_W'(i))        regs_q[i] <= wr_data_d;
        else if (host_we && host_addr == PTR_W'(i))    regs_q[i] <= host_wdata;
      end
    end
  end

  // Outputs straight from registers, plus the combinational host read.
  always_comb begin
    sda_oe      = sda_oe_q;
    wr_strobe   = wr_strobe_q;
    wr_addr     = wr_addr_q;
    wr_data     = wr_data_q;
    busy        = busy_q;
    dbg_state_o = state_q;
    host_rdata  = regs_q[host_addr];
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-level I2C master on a wired-AND SDA line,
// register model, scoreboards for write commits and read bytes.
module tb_i2c_target_regfile;
  import i2c_pkg::*;

  localparam int NUM_REGS = 16;
  localparam int PTR_W    = 4;
  localparam int TQ       = 20;   // clk cycles per quarter SCL period

  logic             clk = 1'b0;
  logic             rst;
  logic             scl;
  logic             sda_m;
  logic             sda_line;
  logic             sda_oe;
  logic [PTR_W-1:0] host_addr;
  logic             host_we;
  logic [7:0]       host_wdata;
  logic [7:0]       host_rdata;
  logic             wr_strobe;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             busy;
  i2c_state_e       dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [PTR_W+7:0] exp_q[$];
  logic [7:0]       rd_q[$];
  logic [7:0]       mdl [NUM_REGS];
  logic             oe_seen, busy_seen;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_regfile #(.SLAVE_ADDR(7'h50), .NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .scl         (scl),
    .sda_i       (sda_line),
    .sda_oe      (sda_oe),
    .host_addr   (host_addr),
    .host_we     (host_we),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write-commit scoreboard: pop on every wr_strobe.
  always @(negedge clk) begin
    if (wr_strobe) begin
      if (exp_q.size() == 0) check("wr_unexpected", 32'(wr_strobe), 32'd0);
      else check("wr_commit", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
    end
    if (sda_oe) oe_seen = 1'b1;
    if (busy)   busy_seen = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_q();
    repeat (TQ) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    b = sda_line; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(master_ack);
  endtask

  task automatic exp_wr(input int a, input logic [7:0] d);
    exp_q.push_back({a[PTR_W-1:0], d});
    mdl[a] = d;
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    @(negedge clk);
    host_addr = a[PTR_W-1:0]; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic check_reg(input string tag, input int a);
    host_addr = a[PTR_W-1:0];
    #1;
    check(tag, 32'(host_rdata), 32'(mdl[a]));
  endtask

  task automatic check_all_regs(input string tag);
    for (int a = 0; a < NUM_REGS; a++) check_reg(tag, a);
  endtask

  // Hold a host write to one index until the next I2C commit is seen.
  task automatic host_hammer(input int a, input logic [7:0] d);
    host_addr = a[PTR_W-1:0]; host_wdata = d; host_we = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (wr_strobe) break;
    end
    check("hammer_strobe_seen", 32'(wr_strobe), 32'd1);
    host_we = 1'b0;
  endtask

  task automatic pop_rd(input string tag, input logic [7:0] got);
    if (rd_q.size() == 0) check({tag, "_noexp"}, 32'(got), 32'hFFFF_FFFF);
    else check(tag, 32'(got), 32'(rd_q.pop_front()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] b8;
    rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
    host_addr = '0; host_we = 1'b0; host_wdata = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = 8'h00;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_all_regs("rst_reg");

    // Two-byte write at pointer 3
    bus_start();
    write_byte(8'hA0, ack); check("t1_addr_ack", 32'(ack), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    write_byte(8'h03, ack); check("t1_ptr_ack", 32'(ack), 32'd0);
    exp_wr(3, 8'hA5);
    write_byte(8'hA5, ack); check("t1_d0_ack", 32'(ack), 32'd0);
    exp_wr(4, 8'h5A);
    write_byte(8'h5A, ack); check("t1_d1_ack", 32'(ack), 32'd0);
    bus_stop();
    check("t1_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t1_busy_off", 32'(busy), 32'd0);
    check_reg("t1_reg3", 3);
    check_reg("t1_reg4", 4);

    // Pointer wrap
    bus_start();
    write_byte(8'hA0, ack); check("t2_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h0F, ack); check("t2_ptr_ack", 32'(ack), 32'd0);
    exp_wr(15, 8'h11);
    write_byte(8'h11, ack); check("t2_d0_ack", 32'(ack), 32'd0);
    exp_wr(0, 8'h22);
    write_byte(8'h22, ack); check("t2_d1_ack", 32'(ack), 32'd0);
    bus_stop();
    check_reg("t2_reg15", 15);
    check_reg("t2_reg0", 0);

    // Combined-format read after host write
    host_write(2, 8'hC3);
    bus_start();
    write_byte(8'hA0, ack); check("t3_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h02, ack); check("t3_ptr_ack", 32'(ack), 32'd0);
    bus_rstart();
    rd_q.push_back(mdl[2]);
    rd_q.push_back(mdl[3]);
    write_byte(8'hA1, ack); check("t3_raddr_ack", 32'(ack), 32'd0);
    read_byte(d, 1'b0); pop_rd("t3_rd0", d);
    read_byte(d, 1'b1); pop_rd("t3_rd1", d);
    check("t3_wait_stop", 32'(dbg_state), 32'(ST_WAIT_STOP));
    check("t3_sda_released", 32'(sda_oe), 32'd0);
    bus_stop();
    check("t3_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Foreign address: never acknowledged, never busy
    oe_seen = 1'b0; busy_seen = 1'b0;
    bus_start();
    write_byte(8'hA2, ack); check("t4_addr_nack", 32'(ack), 32'd1);
    write_byte(8'h00, ack); check("t4_data_nack", 32'(ack), 32'd1);
    bus_stop();
    check("t4_oe_seen", 32'(oe_seen), 32'd0);
    check("t4_busy_seen", 32'(busy_seen), 32'd0);
    check_all_regs("t4_reg");

    // Out-of-range pointer leaves pointer alone
    bus_start();
    write_byte(8'hA0, ack); check("t5_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h05, ack); check("t5_ptr_ack", 32'(ack), 32'd0);
    exp_wr(5, 8'h77);
    write_byte(8'h77, ack); check("t5_d0_ack", 32'(ack), 32'd0);
    bus_stop();
    host_write(6, 8'h3C);
    bus_start();
    write_byte(8'hA0, ack); check("t5b_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h20, ack); check("t5b_ptr_nack", 32'(ack), 32'd1);
    write_byte(8'h99, ack); check("t5b_data_nack", 32'(ack), 32'd1);
    bus_stop();
    check_all_regs("t5_reg");
    bus_start();
    rd_q.push_back(mdl[6]);
    write_byte(8'hA1, ack); check("t5c_addr_ack", 32'(ack), 32'd0);
    read_byte(d, 1'b1); pop_rd("t5c_rd_ptr_kept", d);
    bus_stop();

    // Host and I2C writes in the same cycle
    bus_start();
    write_byte(8'hA0, ack); check("t6_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h08, ack); check("t6_ptr_ack", 32'(ack), 32'd0);
    exp_wr(8, 8'hD4);
    fork
      write_byte(8'hD4, ack);
      host_hammer(8, 8'hEE);
    join
    check("t6_d0_ack", 32'(ack), 32'd0);
    exp_wr(9, 8'hB7);
    mdl[10] = 8'h4B;
    fork
      write_byte(8'hB7, ack);
      host_hammer(10, 8'h4B);
    join
    check("t6_d1_ack", 32'(ack), 32'd0);
    bus_stop();
    check_reg("t6_same_reg_i2c_wins", 8);
    check_reg("t6_reg9", 9);
    check_reg("t6_reg10_host", 10);

    // Reset while ACKing a data byte
    bus_start();
    write_byte(8'hA0, ack); check("t7_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h01, ack); check("t7_ptr_ack", 32'(ack), 32'd0);
    exp_wr(1, 8'hE1);
    b8 = 8'hE1;
    for (int i = 7; i >= 0; i--) write_bit(b8[i]);
    sda_m = 1'b1;
    check("t7_ack_driven", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    #1;
    check("t7_async_release", 32'(sda_oe), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_state", 32'(dbg_state), 32'(ST_IDLE));
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = 8'h00;
    check_all_regs("t7_reg_cleared");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    scl = 1'b1; wait_q();
    bus_start();
    write_byte(8'hA0, ack); check("t7b_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h07, ack); check("t7b_ptr_ack", 32'(ack), 32'd0);
    exp_wr(7, 8'h42);
    write_byte(8'h42, ack); check("t7b_d0_ack", 32'(ack), 32'd0);
    bus_stop();
    check_reg("t7b_reg7", 7);
    check("t7b_busy_off", 32'(busy), 32'd0);

    repeat (10) @(negedge clk);
    check("wr_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

Parametrised I2C target (slave) with an internal byte-wide register file, supporting multi-byte writes and reads with pointer auto-increment, repeated START and STOP detection. Sits between the board-level open-drain SCL/SDA pins and on-chip logic. The I2C side is a standard target. The host side is a synchronous register port plus a write-notify strobe. It supersedes the write-only single-byte target.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit target address matched on the address byte
- NUM_REGS, 16, register count; power of two, 2..256
- PTR_W, $clog2(NUM_REGS), pointer width (derived, not overridden)
- SYNC_STAGES, 2, synchroniser depth on scl/sda inputs (≥2)

- clk  in  1  system clock; must be ≥8× SCL rate
- rst  in  1  reset, asynchronous, active-high
- scl  in  1  I2C clock pin (input only; no clock stretching)
- sda_i  in  1  SDA pin value
- sda_oe  out  1  1 = pull SDA low; pad drives 0 when set, else Hi-Z
- host_addr  in  PTR_W  host register index
- host_we  in  1  host write enable
- host_wdata  in  8  host write data
- host_rdata  out  8  register[host_addr], combinational read
- wr_strobe  out  1  one-cycle pulse when an I2C write commits a register
- wr_addr  out  PTR_W  index written; valid with wr_strobe
- wr_data  out  8  byte written; valid with wr_strobe
- busy  out  1  high from addressed START+match until STOP/NACK return to IDLE

## Operation
- Reset: sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, pointer=0, all registers 0x00, state IDLE.
- START = synced sda falls while synced scl high; STOP = synced sda rises while scl high. START in any state → ADDR, bit count 0. STOP in any state → IDLE, sda_oe=0.
- States: IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_WDATA, RDATA, RACK, WAIT_STOP.
- ADDR: shift 8 bits MSB-first on scl rising edges. If addr[7:1]==SLAVE_ADDR → ACK_ADDR, else WAIT_STOP (no ACK).
- ACK_ADDR: R/W=0 → PTR. R/W=1 → RDATA, loading shift register from register[pointer].
- PTR: 8 bits received. Value < NUM_REGS → pointer updated, ACK, → WDATA. Otherwise NACK, pointer unchanged, → WAIT_STOP.
- WDATA: 8 bits received → register[pointer] written, wr_strobe pulse, ACK. Pointer then increments modulo NUM_REGS (wrap at NUM_REGS-1 → 0). Unbounded byte count until STOP/START.
- RDATA: target drives bits MSB-first; bit 0 is sda_oe=1, bit 1 is release. Pointer increments after each byte.
- RACK: sample master bit on scl rise. ACK (0) → reload next byte, → RDATA. NACK (1) → WAIT_STOP.
- Repeated START after PTR write with R/W=1 reads from the newly set pointer (combined-format read).
- Simultaneous host_we and I2C commit to same register in same cycle: I2C write wins. Different registers: both commit.

## Timing
- Input latency: SYNC_STAGES+1 clk from pin to edge detect.
- sda_oe changes only on the clk after a detected scl falling edge. ACK is asserted on the fall ending bit 8 and released on the fall ending the ACK bit. Read data bit N is set on the fall preceding its clock pulse.
- Register write and wr_strobe occur 1 clk after the 8th data-bit rising edge is detected, before ACK is driven.
- host_rdata is combinational; host writes land at next clk edge.
- Reset mid-transaction releases SDA in the same cycle (asynchronous).

## Structure
- Package i2c_pkg: state enum, START/STOP/ACK/NACK constants, SLAVE_ADDR default.
- Sub-module i2c_bus_sync: synchronisers plus scl_rise/scl_fall/start/stop detectors. Reusable by the master.
- Register array and FSM live in the top module.

## Test plan
- Write 0x50+W, ptr 0x03, data 0xA5, 0x5A, STOP → ACKs on all 4 bytes. reg[3]=0xA5, reg[4]=0x5A. Two wr_strobe pulses with wr_addr 3, 4.
- Write ptr 0x0F, data 0x11, 0x22 (NUM_REGS=16) → reg[15]=0x11, reg[0]=0x22 (wrap).
- Host writes reg[2]=0xC3. Then I2C write ptr 0x02, repeated START, 0x50+R, master ACK then NACK → bytes 0xC3 then reg[3] driven. WAIT_STOP, then IDLE on STOP.
- Address 0x51 → no ACK (sda_oe stays 0 throughout), busy=0, no register change.
- Ptr byte 0x20 (≥NUM_REGS) → NACK, subsequent data ignored, pointer unchanged.
- Assert rst during the ACK of a data byte → sda_oe=0 immediately. All registers 0x00. Next transaction is accepted normally.
